// File: rtl/sng_pkg.sv
// sng_pkg: shared types and constants for the stochastic-number generator.
//   state_e          stream FSM states (IDLE, RUN, FIN)
//   ADDR_*           DATA_ADDR register selects
//   TAPS8/16/32      Galois feedback masks (right-shift form) for the
//                    maximal-length polynomials of each legal WIDTH
//   sng_taps(w)      picks the mask for a given WIDTH
package sng_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

    localparam logic [1:0] ADDR_VALUE = 2'd0;
    localparam logic [1:0] ADDR_SEED  = 2'd1;
    localparam logic [1:0] ADDR_LEN   = 2'd2;
    localparam logic [1:0] ADDR_CMD   = 2'd3;

    // x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1, x^32+x^22+x^2+x+1
    localparam logic [31:0] TAPS8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS16 = 32'h0000_B400;
    localparam logic [31:0] TAPS32 = 32'h8020_0003;

    function automatic logic [31:0] sng_taps(input int w);
        return w == 8 ? TAPS8 : w == 16 ? TAPS16 : TAPS32;
    endfunction

endpackage

// File: rtl/sng_lfsr.sv
// sng_lfsr: maximal-length Galois LFSR with seed load and advance enable.
//   CLK, RST_X   clock, asynchronous active-low reset (state resets to 1)
//   load_i       load seed_i this cycle (a zero seed loads 1)
//   seed_i       seed value
//   advance_i    step the LFSR one position
//   state_o      current LFSR state, never 0
module sng_lfsr
    import sng_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(sng_taps(WIDTH));

    logic [WIDTH-1:0] l_q, l_d;

    // Zero is the lock-up state of an XOR LFSR, so a zero seed becomes 1.
    always_comb
        l_d = load_i    ? (seed_i == '0 ? WIDTH'(1) : seed_i) :
              advance_i ? (l_q >> 1) ^ (l_q[0] ? TAPS : '0)   : l_q;

    always_ff @(posedge CLK or negedge RST_X)
        if (!RST_X) l_q <= WIDTH'(1);
        else        l_q <= l_d;

    assign state_o = l_q;

endmodule

// File: rtl/sn_generator.sv
// sn_generator: converts a bus-programmed signed value into a sign-magnitude
// stochastic bitstream of programmed length.
//   CLK, RST_X         clock, asynchronous active-low reset
//   DATA_IN/ADDR/WE    register writes: 0 value, 1 seed, 2 length, 3 command
//   SN_OUT_P/SN_OUT_N  positive / negative rail stream bits
//   SN_VALID           stream bit valid (downstream counter enable)
//   BUSY               stream in progress
//   DONE               one-cycle pulse at end of stream
//   DATA_OUT           status {BUSY, remaining[30:0]}, one cycle behind
// Build option SNG_BIT_REVERSE_EN: compare the bit-reversed LFSR state.
module sn_generator
    import sng_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] DATA_IN,
    input  logic [1:0]  DATA_ADDR,
    input  logic        DATA_WE,
    output logic        SN_OUT_P,
    output logic        SN_OUT_N,
    output logic        SN_VALID,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] DATA_OUT
);

    state_e           state_q;
    logic             sign_q;
    logic [WIDTH-1:0] mag_q;
    logic [30:0]      len_q, rem_q;
    logic             p_q, n_q, valid_q, busy_q, done_q;
    logic [31:0]      dout_q;

    logic             wr_seed, start, abort, emit, b;
    logic [WIDTH-1:0] lfsr, cmp;

    assign wr_seed = DATA_WE && DATA_ADDR == ADDR_SEED && !busy_q;
    assign start   = DATA_WE && DATA_ADDR == ADDR_CMD && DATA_IN[0] && !DATA_IN[1];
    assign abort   = DATA_WE && DATA_ADDR == ADDR_CMD && DATA_IN[1];

    // A bit is produced (and the LFSR stepped) on the start cycle and on
    // every RUN cycle except the one showing the final bit.
    assign emit = (state_q == IDLE && start && len_q != '0) ||
                  (state_q == RUN && !abort && rem_q > 31'd1);

    sng_lfsr #(.WIDTH(WIDTH)) u_lfsr (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .load_i    (wr_seed),
        .seed_i    (DATA_IN[WIDTH-1:0]),
        .advance_i (emit),
        .state_o   (lfsr)
    );

`ifdef SNG_BIT_REVERSE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign cmp[i] = lfsr[WIDTH-1-i];
    end
`else
    assign cmp = lfsr;
`endif

    assign b = cmp <= mag_q;

    always_ff @(posedge CLK or negedge RST_X)
        if (!RST_X) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            p_q     <= 1'b0;
            n_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            if (DATA_WE && DATA_ADDR == ADDR_VALUE) begin
                sign_q <= DATA_IN[31];
                mag_q  <= DATA_IN[WIDTH-1:0];
            end
            if (DATA_WE && DATA_ADDR == ADDR_LEN && !busy_q) len_q <= DATA_IN[30:0];
            p_q     <= emit && !sign_q && b;
            n_q     <= emit && sign_q && b;
            valid_q <= emit;
            done_q  <= 1'b0;
            dout_q  <= {busy_q, rem_q};
            case (state_q)
                IDLE:
                    if (start) begin
                        if (len_q != '0) begin
                            state_q <= RUN;
                            rem_q   <= len_q;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                RUN:
                    if (abort) begin
                        state_q <= IDLE;
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (rem_q == 31'd1) begin
                        state_q <= FIN;
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        rem_q <= rem_q - 31'd1;
                    end
                default: state_q <= IDLE;
            endcase
        end

    assign SN_OUT_P = p_q;
    assign SN_OUT_N = n_q;
    assign SN_VALID = valid_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign DATA_OUT = dout_q;

endmodule

// File: tb/tb_sn_generator.sv
// tb_sn_generator: directed self-checking bench for sn_generator (WIDTH=16).
module tb_sn_generator;
    import sng_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic [31:0] DATA_IN = '0;
    logic [1:0]  DATA_ADDR = '0;
    logic        DATA_WE = 1'b0;
    logic        SN_OUT_P, SN_OUT_N, SN_VALID, BUSY, DONE;
    logic [31:0] DATA_OUT;

    int vectors = 0;
    int errors = 0;

    sn_generator #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .DATA_IN   (DATA_IN),
        .DATA_ADDR (DATA_ADDR),
        .DATA_WE   (DATA_WE),
        .SN_OUT_P  (SN_OUT_P),
        .SN_OUT_N  (SN_OUT_N),
        .SN_VALID  (SN_VALID),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DATA_OUT  (DATA_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge CLK);
        DATA_ADDR = a;
        DATA_IN   = d;
        DATA_WE   = 1'b1;
        @(negedge CLK);
        DATA_WE   = 1'b0;
    endtask

    // Starts a stream of len bits (len >= 1) and samples every cycle.
    task automatic stream(input int len, output int np, output int nn,
                          output logic [31:0] pat, output logic [31:0] d2);
        int bad;
        wr(ADDR_LEN, len);
        wr(ADDR_CMD, 32'd1);
        np = 0; nn = 0; pat = '0; d2 = '0; bad = 0;
        vectors++;
        if (BUSY !== 1'b1) begin
            errors++; $display("FAIL busy_start: got %b expected 1", BUSY);
        end
        for (int k = 0; k < len; k++) begin
            if (SN_VALID !== 1'b1 || DONE !== 1'b0) bad++;
            np += int'(SN_OUT_P);
            nn += int'(SN_OUT_N);
            if (k < 32) pat[k] = SN_OUT_P;
            if (k == 1) d2 = DATA_OUT;
            @(negedge CLK);
        end
        vectors++;
        if (bad != 0) begin
            errors++; $display("FAIL valid_run: got %0d bad cycles expected 0", bad);
        end
        vectors++;
        if ({DONE, BUSY, SN_VALID, SN_OUT_P, SN_OUT_N} !== 5'b10000) begin
            errors++;
            $display("FAIL done_pulse: got done/busy/valid/p/n=%b expected 10000",
                     {DONE, BUSY, SN_VALID, SN_OUT_P, SN_OUT_N});
        end
        @(negedge CLK);
        vectors++;
        if (DONE !== 1'b0) begin
            errors++; $display("FAIL done_width: got %b expected 0", DONE);
        end
    endtask

    task automatic test_reset;
        vectors++;
        if ({SN_OUT_P, SN_OUT_N, SN_VALID, BUSY, DONE} !== 5'b0 || DATA_OUT !== 32'd0) begin
            errors++;
            $display("FAIL reset: got outs=%b dout=%h expected 0/0",
                     {SN_OUT_P, SN_OUT_N, SN_VALID, BUSY, DONE}, DATA_OUT);
        end
    endtask

    task automatic test_zero_mag;
        int np, nn;
        logic [31:0] pat, d2;
        wr(ADDR_VALUE, 32'h0000_0000);
        stream(100, np, nn, pat, d2);
        vectors++;
        if (np != 0 || nn != 0) begin
            errors++; $display("FAIL zero_mag: got p=%0d n=%0d expected 0/0", np, nn);
        end
        vectors++;
        if (d2 !== 32'h8000_0064) begin
            errors++; $display("FAIL status: got %h expected 80000064", d2);
        end
    endtask

    task automatic test_full_pos;
        int np, nn;
        logic [31:0] pat, d2;
        wr(ADDR_VALUE, 32'h0000_FFFF);
        stream(100, np, nn, pat, d2);
        vectors++;
        if (np != 100 || nn != 0) begin
            errors++; $display("FAIL full_pos: got p=%0d n=%0d expected 100/0", np, nn);
        end
    endtask

    task automatic test_full_neg;
        int np, nn;
        logic [31:0] pat, d2;
        wr(ADDR_VALUE, 32'h8000_FFFF);
        stream(100, np, nn, pat, d2);
        vectors++;
        if (np != 0 || nn != 100) begin
            errors++; $display("FAIL full_neg: got p=%0d n=%0d expected 0/100", np, nn);
        end
    endtask

    // L runs 1, B400, 5A00, 2D00 from seed 1.
    task automatic test_sequence;
        int np, nn;
        logic [31:0] pat, d2, e1, e2;
`ifdef SNG_BIT_REVERSE_EN
        e1 = 32'd7; e2 = 32'd1;
`else
        e1 = 32'd5; e2 = 32'd0;
`endif
        wr(ADDR_SEED, 32'd1);
        wr(ADDR_VALUE, 32'h0000_B3FF);
        stream(3, np, nn, pat, d2);
        vectors++;
        if (pat !== e1) begin
            errors++; $display("FAIL lfsr_seq: got %h expected %h", pat, e1);
        end
        wr(ADDR_VALUE, 32'h0000_2CFF);
        stream(1, np, nn, pat, d2);
        vectors++;
        if (pat !== e2) begin
            errors++; $display("FAIL lfsr_continue: got %h expected %h", pat, e2);
        end
    endtask

    task automatic test_half;
        int np, nn;
        logic [31:0] pat, d2;
        wr(ADDR_SEED, 32'd1);
        wr(ADDR_VALUE, 32'h0000_8000);
        stream(65535, np, nn, pat, d2);
        vectors++;
        if (np != 32768 || nn != 0) begin
            errors++; $display("FAIL half_period: got p=%0d n=%0d expected 32768/0", np, nn);
        end
    endtask

    task automatic test_seed_zero;
        int np, nn;
        logic [31:0] pat, d2, e;
`ifdef SNG_BIT_REVERSE_EN
        e = 32'd1;
`else
        e = 32'd0;
`endif
        wr(ADDR_SEED, 32'd0);
        wr(ADDR_VALUE, 32'h0000_0000);
        stream(1, np, nn, pat, d2);
        vectors++;
        if (np != 0) begin
            errors++; $display("FAIL seed_zero: got p=%0d expected 0", np);
        end
        wr(ADDR_VALUE, 32'h0000_B3FF);
        stream(1, np, nn, pat, d2);
        vectors++;
        if (pat !== e) begin
            errors++; $display("FAIL seed_zero_next: got %h expected %h", pat, e);
        end
    endtask

    task automatic test_len_zero;
        wr(ADDR_LEN, 32'd0);
        wr(ADDR_CMD, 32'd1);
        vectors++;
        if ({DONE, BUSY, SN_VALID} !== 3'b100) begin
            errors++; $display("FAIL len_zero: got done/busy/valid=%b expected 100", {DONE, BUSY, SN_VALID});
        end
        @(negedge CLK);
        vectors++;
        if ({DONE, BUSY, SN_VALID} !== 3'b000) begin
            errors++; $display("FAIL len_zero_after: got %b expected 000", {DONE, BUSY, SN_VALID});
        end
        wr(ADDR_LEN, 32'd5);
        wr(ADDR_CMD, 32'd3);
        vectors++;
        if ({DONE, BUSY, SN_VALID} !== 3'b000) begin
            errors++; $display("FAIL abort_wins: got %b expected 000", {DONE, BUSY, SN_VALID});
        end
    endtask

    task automatic test_abort;
        int dones = 0;
        wr(ADDR_VALUE, 32'h0000_FFFF);
        wr(ADDR_LEN, 32'd50);
        wr(ADDR_CMD, 32'd1);
        for (int k = 1; k < 10; k++) @(negedge CLK);
        vectors++;
        if (SN_VALID !== 1'b1 || SN_OUT_P !== 1'b1) begin
            errors++; $display("FAIL abort_pre: got valid=%b p=%b expected 1/1", SN_VALID, SN_OUT_P);
        end
        DATA_ADDR = ADDR_CMD;
        DATA_IN   = 32'd2;
        DATA_WE   = 1'b1;
        @(negedge CLK);
        DATA_WE   = 1'b0;
        vectors++;
        if ({SN_VALID, BUSY, SN_OUT_P, DONE} !== 4'b0) begin
            errors++; $display("FAIL abort: got valid/busy/p/done=%b expected 0000", {SN_VALID, BUSY, SN_OUT_P, DONE});
        end
        for (int k = 0; k < 60; k++) begin
            dones += int'(DONE);
            @(negedge CLK);
        end
        vectors++;
        if (dones != 0 || DATA_OUT !== 32'd0) begin
            errors++; $display("FAIL abort_after: got dones=%0d dout=%h expected 0/0", dones, DATA_OUT);
        end
    endtask

    task automatic test_reset_mid;
        int np, nn;
        logic [31:0] pat, d2, e;
`ifdef SNG_BIT_REVERSE_EN
        e = 32'd0;
`else
        e = 32'd1;
`endif
        wr(ADDR_LEN, 32'd50);
        wr(ADDR_CMD, 32'd1);
        for (int k = 0; k < 4; k++) @(negedge CLK);
        vectors++;
        if (SN_VALID !== 1'b1 || DATA_OUT === 32'd0) begin
            errors++; $display("FAIL reset_mid_pre: got valid=%b dout=%h expected 1/nonzero", SN_VALID, DATA_OUT);
        end
        RST_X = 1'b0;
        #1;
        vectors++;
        if ({SN_OUT_P, SN_OUT_N, SN_VALID, BUSY, DONE} !== 5'b0 || DATA_OUT !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got outs=%b dout=%h expected 0/0",
                     {SN_OUT_P, SN_OUT_N, SN_VALID, BUSY, DONE}, DATA_OUT);
        end
        @(negedge CLK);
        RST_X = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({SN_VALID, BUSY, DONE} !== 3'b0) begin
            errors++; $display("FAIL reset_mid_after: got %b expected 000", {SN_VALID, BUSY, DONE});
        end
        wr(ADDR_VALUE, 32'h0000_0001);
        stream(1, np, nn, pat, d2);
        vectors++;
        if (pat !== e) begin
            errors++; $display("FAIL reset_lfsr: got %h expected %h", pat, e);
        end
    endtask

    initial begin
        #22 RST_X = 1'b1;
        @(negedge CLK);
        test_reset;
        test_zero_mag;
        test_full_pos;
        test_full_neg;
        test_sequence;
        test_half;
        test_seed_zero;
        test_len_zero;
        test_abort;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
